// File: rtl/lcd_init_sequencer.sv
// HD44780-style power-on init: waits, then strobes 8 fixed commands with setup/pulse/hold/wait timing.
// Outputs registered (one cycle from next-state); no backpressure, runs free until done, terminal until reset.
module lcd_init_sequencer #(
    parameter int PWR_CYC   = 750000,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 12,
    parameter int HOLD_CYC  = 2,
    parameter int LONG_CYC  = 205000,
    parameter int MID_CYC   = 5000,
    parameter int CMD_CYC   = 2000,
    parameter int CLR_CYC   = 76000
) (
    input  logic       clk,
    input  logic       reset,
    output logic       RS,
    output logic       RW,
    output logic       E,
    output logic [7:0] DATA,
    output logic       done
);

    localparam logic [2:0] ST_POWERUP = 3'd0;
    localparam logic [2:0] ST_SETUP   = 3'd1;
    localparam logic [2:0] ST_PULSE   = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_WAIT    = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    localparam logic [19:0] PWR_LD   = 20'(PWR_CYC);
    localparam logic [19:0] SETUP_LD = 20'(SETUP_CYC);
    localparam logic [19:0] PULSE_LD = 20'(PULSE_CYC);
    localparam logic [19:0] HOLD_LD  = 20'(HOLD_CYC);
    localparam logic [19:0] LONG_LD  = 20'(LONG_CYC);
    localparam logic [19:0] MID_LD   = 20'(MID_CYC);
    localparam logic [19:0] CMD_LD   = 20'(CMD_CYC);
    localparam logic [19:0] CLR_LD   = 20'(CLR_CYC);

    logic [2:0]  state, nxt_state;
    logic [2:0]  idx, nxt_idx;
    logic [19:0] cnt, nxt_cnt;

    function automatic logic [7:0] cmd_byte(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: cmd_byte = 8'h30;
            3'd3:             cmd_byte = 8'h38;
            3'd4:             cmd_byte = 8'h08;
            3'd5:             cmd_byte = 8'h01;
            3'd6:             cmd_byte = 8'h06;
            default:          cmd_byte = 8'h0C;
        endcase
    endfunction

    function automatic logic [19:0] wait_len(input logic [2:0] i);
        case (i)
            3'd0:    wait_len = LONG_LD;
            3'd1:    wait_len = MID_LD;
            3'd5:    wait_len = CLR_LD;
            default: wait_len = CMD_LD;
        endcase
    endfunction

    // Each state lasts exactly its load value: the transition happens on the edge where cnt reaches 1.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt - 20'd1;
        if (state == ST_DONE) begin
            nxt_cnt = cnt;
        end else if (cnt <= 20'd1) begin
            case (state)
                ST_POWERUP: begin
                    nxt_state = ST_SETUP;
                    nxt_cnt   = SETUP_LD;
                end
                ST_SETUP: begin
                    nxt_state = ST_PULSE;
                    nxt_cnt   = PULSE_LD;
                end
                ST_PULSE: begin
                    nxt_state = ST_HOLD;
                    nxt_cnt   = HOLD_LD;
                end
                ST_HOLD: begin
                    nxt_state = ST_WAIT;
                    nxt_cnt   = wait_len(idx);
                end
                ST_WAIT: begin
                    if (idx == 3'd7) begin
                        nxt_state = ST_DONE;
                        nxt_cnt   = 20'd0;
                    end else begin
                        nxt_state = ST_SETUP;
                        nxt_idx   = idx + 3'd1;
                        nxt_cnt   = SETUP_LD;
                    end
                end
                default: begin
                    nxt_state = ST_DONE;
                    nxt_cnt   = 20'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_POWERUP;
            idx   <= 3'd0;
            cnt   <= PWR_LD;
            RS    <= 1'b0;
            RW    <= 1'b0;
            E     <= 1'b0;
            DATA  <= 8'h00;
            done  <= 1'b0;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            cnt   <= nxt_cnt;
            RS    <= 1'b0;
            RW    <= 1'b0;
            E     <= (nxt_state == ST_PULSE);
            done  <= (nxt_state == ST_DONE);
            DATA  <= (nxt_state == ST_POWERUP) ? 8'h00 : cmd_byte(nxt_idx);
        end
    end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed bench for lcd_init_sequencer with shortened timing parameters.
module tb_lcd_init_sequencer;

    logic       clk;
    logic       reset;
    logic       RS;
    logic       RW;
    logic       E;
    logic [7:0] DATA;
    logic       done;

    int checks = 0;
    int fails  = 0;

    lcd_init_sequencer #(
        .PWR_CYC(10), .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2),
        .LONG_CYC(8), .MID_CYC(4), .CMD_CYC(3), .CLR_CYC(6)
    ) dut (
        .clk(clk), .reset(reset), .RS(RS), .RW(RW), .E(E), .DATA(DATA), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Observes one full sequence starting right after reset release; edge 1 is the first posedge.
    task automatic observe_run(input string tag);
        logic [7:0] exp_tab [8];
        int         rise_e [8];
        int         fall_e [8];
        logic [7:0] fall_dat [8];
        int         pulses, done_edge, last_chg;
        int         pins_bad, late_pulse, setup_bad, hold_bad, data_in_pulse, width_bad;
        logic       prev_e;
        logic [7:0] prev_data;
        exp_tab = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        for (int i = 0; i < 8; i++) begin
            rise_e[i] = 0; fall_e[i] = 0; fall_dat[i] = 8'hxx;
        end
        pulses = 0; done_edge = -1; last_chg = 0;
        pins_bad = 0; late_pulse = 0; setup_bad = 0; hold_bad = 0;
        data_in_pulse = 0; width_bad = 0;
        prev_e = E; prev_data = DATA;
        for (int n = 1; n <= 140; n++) begin
            @(posedge clk);
            #1;
            if (RS !== 1'b0 || RW !== 1'b0) pins_bad++;
            if (E === 1'b1 && prev_e === 1'b0) begin
                if (done_edge >= 0) late_pulse++;
                if (pulses < 8) rise_e[pulses] = n;
                if (n - last_chg < 2) setup_bad++;
            end
            if (E === 1'b0 && prev_e === 1'b1) begin
                if (pulses < 8) begin
                    fall_e[pulses]   = n;
                    fall_dat[pulses] = DATA;
                end
                pulses++;
            end
            if (DATA !== prev_data) begin
                if (E === 1'b1) data_in_pulse++;
                if (pulses > 0 && pulses <= 8 && n - fall_e[pulses-1] < 2) hold_bad++;
                last_chg = n;
            end
            if (done === 1'b1 && done_edge < 0) done_edge = n;
            prev_e = E;
            prev_data = DATA;
        end
        checks++;
        if (done_edge !== 99) begin
            fails++; $display("FAIL %s done_edge: got %0d want 99", tag, done_edge);
        end
        checks++;
        if (pulses !== 8) begin
            fails++; $display("FAIL %s pulse_count: got %0d want 8", tag, pulses);
        end
        for (int i = 0; i < 8; i++) begin
            if (fall_e[i] - rise_e[i] != 3) width_bad++;
        end
        checks++;
        if (width_bad !== 0) begin
            fails++; $display("FAIL %s pulse_width: %0d pulses not 3 cycles wide", tag, width_bad);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (fall_dat[i] !== exp_tab[i]) begin
                fails++;
                $display("FAIL %s data_at_fall[%0d]: got %h want %h", tag, i, fall_dat[i], exp_tab[i]);
            end
        end
        checks++;
        if (rise_e[1] - fall_e[0] !== 12) begin
            fails++; $display("FAIL %s gap_0_1: got %0d want 12", tag, rise_e[1] - fall_e[0]);
        end
        checks++;
        if (rise_e[6] - fall_e[5] !== 10) begin
            fails++; $display("FAIL %s gap_5_6: got %0d want 10", tag, rise_e[6] - fall_e[5]);
        end
        checks++;
        if (rise_e[0] !== 12) begin
            fails++; $display("FAIL %s first_rise: got %0d want 12", tag, rise_e[0]);
        end
        checks++;
        if (setup_bad !== 0 || hold_bad !== 0 || data_in_pulse !== 0) begin
            fails++;
            $display("FAIL %s data_stability: setup=%0d hold=%0d in_pulse=%0d want 0,0,0",
                     tag, setup_bad, hold_bad, data_in_pulse);
        end
        checks++;
        if (pins_bad !== 0) begin
            fails++; $display("FAIL %s rs_rw_static: %0d bad cycles want 0", tag, pins_bad);
        end
        checks++;
        if (late_pulse !== 0) begin
            fails++; $display("FAIL %s pulse_after_done: got %0d want 0", tag, late_pulse);
        end
        checks++;
        if (done !== 1'b1 || E !== 1'b0 || DATA !== 8'h0C) begin
            fails++;
            $display("FAIL %s done_hold: done=%b E=%b DATA=%h want 1,0,0c", tag, done, E, DATA);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (RS !== 1'b0 || RW !== 1'b0 || E !== 1'b0 || DATA !== 8'h00 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: RS=%b RW=%b E=%b DATA=%h done=%b want 0,0,0,00,0",
                     RS, RW, E, DATA, done);
        end
    endtask

    task automatic test_nominal();
        release_reset();
        observe_run("nominal");
    endtask

    task automatic test_reset_mid_pulse();
        int rises;
        logic prev_e;
        reset = 1'b1;
        @(negedge clk);
        release_reset();
        rises = 0;
        prev_e = 1'b0;
        for (int n = 0; n < 200 && rises < 5; n++) begin
            @(posedge clk);
            #1;
            if (E === 1'b1 && prev_e === 1'b0) rises++;
            prev_e = E;
        end
        checks++;
        if (rises !== 5) begin
            fails++; $display("FAIL midpulse_reach: got %0d rises want 5", rises);
        end
        // Second cycle of pulse 4: E must still be high before reset hits.
        @(posedge clk);
        #1;
        checks++;
        if (E !== 1'b1 || DATA !== 8'h08) begin
            fails++; $display("FAIL midpulse_pre: E=%b DATA=%h want 1,08", E, DATA);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (E !== 1'b0 || DATA !== 8'h00 || done !== 1'b0) begin
            fails++; $display("FAIL midpulse_async: E=%b DATA=%h done=%b want 0,00,0", E, DATA, done);
        end
        repeat (2) @(posedge clk);
        release_reset();
        observe_run("after_midpulse");
    endtask

    task automatic test_reset_in_done();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || E !== 1'b0 || DATA !== 8'h00) begin
            fails++; $display("FAIL done_reset_async: done=%b E=%b DATA=%h want 0,0,00", done, E, DATA);
        end
        release_reset();
        observe_run("after_done_reset");
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_nominal();
        test_reset_mid_pulse();
        test_reset_in_done();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/lcd_init_sequencer.md
LCD_INIT_SEQUENCER -- requirements
Module: lcd_init_sequencer

Interface
REQ-001 SHALL have parameter PWR_CYC, default 750000, meaning power-up wait cycles (15 ms at 50 MHz).
REQ-002 SHALL have parameter SETUP_CYC, default 2, meaning cycles DATA/RS are stable before E rises.
REQ-003 SHALL have parameter PULSE_CYC, default 12, meaning E high width in cycles.
REQ-004 SHALL have parameter HOLD_CYC, default 2, meaning cycles DATA is held after E falls.
REQ-005 SHALL have parameter LONG_CYC, default 205000, meaning wait after command 0 (4.1 ms).
REQ-006 SHALL have parameter MID_CYC, default 5000, meaning wait after command 1 (100 us).
REQ-007 SHALL have parameter CMD_CYC, default 2000, meaning wait after commands 2,3,4,6,7 (40 us).
REQ-008 SHALL have parameter CLR_CYC, default 76000, meaning wait after clear, command 5 (1.52 ms).
REQ-009 SHALL require every cycle parameter to be >= 1; counters SHALL be 20 bits wide.
REQ-010 SHALL have port clk, input, 1 bit, meaning 50 MHz clock.
REQ-011 SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset; all state SHALL clear immediately on assertion.
REQ-012 SHALL have port RS, output, 1 bit, meaning LCD register select.
REQ-013 SHALL have port RW, output, 1 bit, meaning LCD read/write select.
REQ-014 SHALL have port E, output, 1 bit, meaning LCD enable strobe.
REQ-015 SHALL have port DATA, output, 8 bits, meaning LCD command byte.
REQ-016 SHALL have port done, output, 1 bit, meaning initialisation complete; it gates the mux that hands the bus to the character driver.

Function
REQ-017 SHALL issue the fixed command table in index order: 0:0x30, 1:0x30, 2:0x30, 3:0x38, 4:0x08, 5:0x01, 6:0x06, 7:0x0C.
REQ-018 SHALL implement the states POWERUP, SETUP, PULSE, HOLD, WAIT and DONE, with a 3-bit command index and a single down-counter.
REQ-019 SHALL enter POWERUP with index=0 on reset, and stay there for PWR_CYC cycles after reset deassertion before moving to SETUP.
REQ-020 SHALL, in SETUP, drive DATA=table[index] and E=0 for SETUP_CYC cycles, then move to PULSE.
REQ-021 SHALL, in PULSE, drive E=1 for exactly PULSE_CYC cycles with DATA unchanged, then move to HOLD.
REQ-022 SHALL, in HOLD, drive E=0 for HOLD_CYC cycles with DATA unchanged, then move to WAIT.
REQ-023 SHALL, in WAIT, count the wait for the current index (0:LONG_CYC, 1:MID_CYC, 5:CLR_CYC, else CMD_CYC), keeping DATA unchanged and E=0.
REQ-024 SHALL, at the end of WAIT, increment index and go to SETUP if index<7; if index==7 it SHALL go to DONE without incrementing or wrapping.
REQ-025 SHALL hold RS=0 and RW=0 in every state.
REQ-026 SHALL, in DONE, assert done=1 and E=0 and hold DATA at 0x0C; DONE SHALL be terminal until reset.
REQ-027 SHALL produce exactly 8 E pulses per reset; E SHALL never be high outside PULSE.
REQ-028 SHALL drive all outputs from registers, with no combinational path from state to pins.
REQ-029 SHALL, with default parameters, assert done 1,046,128 cycles after reset deassertion (PWR + 8*(SETUP+PULSE+HOLD) + sum of waits).

Reset
REQ-030 SHALL, while reset is high, drive RS=0, RW=0, E=0, DATA=0x00, done=0, state=POWERUP, index=0 and counter loaded with PWR_CYC.
REQ-031 SHALL, on reset asserted in any state including mid-pulse or DONE, drop E and done in the same instant and restart the full sequence from POWERUP after release.
REQ-032 SHALL treat reset asserted for a single cycle as a full restart.

Verification (params PWR=10, SETUP=2, PULSE=3, HOLD=2, LONG=8, MID=4, CMD=3, CLR=6)
REQ-033 Nominal run: release reset, count edges -> done rises on edge 99; E pulses 8 times, each 3 cycles wide; DATA sampled at each E fall = 30,30,30,38,08,01,06,0C.
REQ-034 Timing: for each pulse, DATA is stable >=2 cycles before E rises and >=2 cycles after E falls; the gap from E fall 0 to E rise 1 is 2+8+2=12 cycles, and from E fall 5 to E rise 6 is 2+6+2=10 cycles.
REQ-035 Reset mid-pulse: assert reset during the 2nd cycle of pulse 4 -> E=0 and DATA=0x00 immediately; after release, 8 fresh pulses occur and done rises on edge 99.
REQ-036 Reset in DONE: assert reset for 1 cycle after done -> done=0 asynchronously; the sequence repeats identically.
REQ-037 Static pins: across the whole run, RS==0 and RW==0 every cycle, and no E pulse occurs after done.
